noc_vc_input_buffer: RTL and testbench
======================================

NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 Parameter VC_NUM, default 4: number of virtual channels (>=2).
REQ-002 Parameter FLIT_W, default 64: flit width in bits.
REQ-003 Parameter DEPTH, default 4: per-VC FIFO depth in flits (power of 2, >=2); upstream initial credit per VC equals DEPTH.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  flit present from upstream link; no ready (credit-based).
REQ-007 in_vc  input  $clog2(VC_NUM)  VC of incoming flit.
REQ-008 in_flit  input  FLIT_W  incoming flit.
REQ-009 credit_ret  output  VC_NUM  one-cycle credit pulse per VC to upstream.
REQ-010 out_valid  output  1  flit offered to downstream flow-control stage.
REQ-011 out_vc  output  $clog2(VC_NUM)  VC of offered flit.
REQ-012 out_flit  output  FLIT_W  offered flit.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 vc_empty  output  VC_NUM  per-VC FIFO empty flags.
REQ-015 err_clr  input  1  clears sticky error bits.
REQ-016 err_status  output  2  sticky errors: [0] overflow, [1] parity.

Function
REQ-017 in_valid=1 writes in_flit into FIFO in_vc at the rising edge; flit is eligible for output the next cycle (no bypass, 1-cycle min latency).
REQ-018 Per-VC occupancy counter width $clog2(DEPTH)+1, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-019 Enqueue to a VC whose count==DEPTH with no same-cycle dequeue of that VC: flit dropped, err_status[0] set; same-cycle dequeue of that VC: flit accepted, count stays DEPTH.
REQ-020 Round-robin arbiter selects among non-empty VCs starting at pointer; out_valid=1 whenever any VC is non-empty.
REQ-021 Once out_valid=1 and out_ready=0, out_vc and out_flit hold stable until handshake.
REQ-022 On handshake (out_valid&&out_ready), head of out_vc popped and pointer becomes out_vc+1 mod VC_NUM.
REQ-023 credit_ret[v] is registered: asserted exactly the cycle after each pop of VC v, one pulse per flit.
REQ-024 Simultaneous enqueue and dequeue on the same VC: count unchanged, both operations take effect.
REQ-025 err_clr has priority over same-cycle error set; bits cleared next cycle.

Reset
REQ-026 On rst_n low: all FIFOs empty, counts 0, pointers 0, arbiter pointer 0, out_valid=0, credit_ret=0, vc_empty all 1, err_status=0.
REQ-027 Reset mid-operation discards buffered flits; no credit_ret pulses for discarded flits; upstream re-initialises credit to DEPTH.
REQ-028 FIFO storage array is not reset.

Configuration
REQ-029 Macro NOC_VCBUF_PARITY_EN: when defined, in_flit[FLIT_W-1] is an even-parity bit over in_flit[FLIT_W-2:0]; mismatched flit is not stored, err_status[1] set, and credit_ret[in_vc] pulses the next cycle to restore upstream credit.
REQ-030 Without NOC_VCBUF_PARITY_EN: no checking, all FLIT_W bits are payload, err_status[1] tied 0.

Structure
REQ-031 Package noc_fc_pkg holds the VC id typedef, credit-count typedef, and err_status bit-index constants.
REQ-032 Arbiter is sub-module noc_rr_arb (request vector, advance strobe, one-hot grant plus encoded index).

Verification
REQ-033 Reset then single flit VC2 at cycle 0 with out_ready=1 -> out_valid cycle 1, out_vc=2, credit_ret=4'b0100 at cycle 2.
REQ-034 Fill VC0 with 4 flits, 5th flit VC0 with out_ready=0 -> 5th dropped, err_status=2'b01, VC0 holds first 4 in order.
REQ-035 One flit each in VC0..VC3, out_ready=1 -> output order 0,1,2,3, then next VC1 flit after VC3 served.
REQ-036 out_ready=0 for 5 cycles with new flits arriving on other VCs -> out_vc/out_flit unchanged throughout.
REQ-037 VC1 full, simultaneous enqueue VC1 and pop VC1 -> no error, count stays 4, credit_ret[1] pulse next cycle.
REQ-038 With NOC_VCBUF_PARITY_EN, flit with bad parity on VC3 -> not output, err_status[1]=1, credit_ret[3] pulse next cycle; err_clr -> err_status=0.

Source files
------------

// File: rtl/noc_fc_pkg.sv
// noc_fc_pkg: shared flow-control types and error-bit indices for the VC input buffer
package noc_fc_pkg;
  localparam int DEF_VC_NUM = 4;
  localparam int DEF_DEPTH = 4;
  localparam int ERR_OVF = 0;
  localparam int ERR_PAR = 1;
  typedef logic [$clog2(DEF_VC_NUM)-1:0] vc_id_t;
  typedef logic [$clog2(DEF_DEPTH):0] cred_cnt_t;
endpackage

// File: rtl/noc_rr_arb.sv
// noc_rr_arb: round-robin arbiter; grant is locked while a request waits unserved
module noc_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] ptr, lidx, pick;
  logic locked, found;
  always_comb begin
    pick = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        pick = W'((int'(ptr) + i) % N);
      end
    end
    idx = locked ? lidx : pick;
    gnt = '0;
    gnt[idx] = |req;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      lidx <= '0;
      locked <= 1'b0;
    end else begin
      if (adv) ptr <= (idx == W'(N - 1)) ? '0 : idx + 1'b1;
      locked <= |req && !adv;
      lidx <= idx;
    end
  end
endmodule

// File: rtl/noc_vc_input_buffer.sv
// noc_vc_input_buffer: credit-based per-VC input FIFOs with round-robin output arbitration
// Optional NOC_VCBUF_PARITY_EN: in_flit[FLIT_W-1] carries even parity over the flit.
module noc_vc_input_buffer
  import noc_fc_pkg::*;
#(
  parameter int VC_NUM = DEF_VC_NUM,
  parameter int FLIT_W = 64,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [$clog2(VC_NUM)-1:0] in_vc,
  input  logic [FLIT_W-1:0]         in_flit,
  output logic [VC_NUM-1:0]         credit_ret,
  output logic                      out_valid,
  output logic [$clog2(VC_NUM)-1:0] out_vc,
  output logic [FLIT_W-1:0]         out_flit,
  input  logic                      out_ready,
  output logic [VC_NUM-1:0]         vc_empty,
  input  logic                      err_clr,
  output logic [1:0]                err_status
);
  localparam int VW = $clog2(VC_NUM);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [FLIT_W-1:0] mem [VC_NUM][DEPTH];
  logic [VC_NUM-1:0][CW-1:0] cnt;
  logic [VC_NUM-1:0][PW-1:0] wp, rp;
  logic [VC_NUM-1:0] req, gnt, wr_v, rd_v, par_ret;
  logic pop, full, wr_en, ovf, par_err;
  logic [1:0] err_q;
`ifdef NOC_VCBUF_PARITY_EN
  assign par_err = in_valid && ^in_flit;
`else
  assign par_err = 1'b0;
`endif
  assign pop = out_valid && out_ready;
  assign full = cnt[in_vc] == CW'(DEPTH);
  // a full VC still accepts when its head leaves in the same cycle
  assign wr_en = in_valid && !par_err && (!full || (pop && out_vc == in_vc));
  assign ovf = in_valid && !par_err && !wr_en;
  assign req = ~vc_empty;
  assign rd_v = {VC_NUM{pop}} & gnt;
  assign out_valid = |req;
  assign out_flit = mem[out_vc][rp[out_vc]];
  assign err_status = err_q;
  always_comb begin
    wr_v = '0;
    par_ret = '0;
    vc_empty = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      wr_v[v] = wr_en && in_vc == VW'(v);
      par_ret[v] = par_err && in_vc == VW'(v);
      vc_empty[v] = cnt[v] == '0;
    end
  end
  noc_rr_arb #(.N(VC_NUM)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .adv  (pop),
    .gnt  (gnt),
    .idx  (out_vc)
  );
  always_ff @(posedge clk) begin
    if (wr_en) mem[in_vc][wp[in_vc]] <= in_flit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      credit_ret <= '0;
      err_q <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        cnt[v] <= cnt[v] + CW'(wr_v[v]) - CW'(rd_v[v]);
        if (wr_v[v]) wp[v] <= wp[v] + 1'b1;
        if (rd_v[v]) rp[v] <= rp[v] + 1'b1;
      end
      credit_ret <= rd_v | par_ret;
      if (err_clr) err_q <= '0;
      else begin
        err_q[ERR_OVF] <= err_q[ERR_OVF] | ovf;
        err_q[ERR_PAR] <= err_q[ERR_PAR] | par_err;
      end
    end
  end
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// tb_noc_vc_input_buffer: directed self-checking bench for the VC input buffer
module tb_noc_vc_input_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [1:0] in_vc;
  logic [63:0] in_flit;
  logic [3:0] credit_ret;
  logic out_valid;
  logic [1:0] out_vc;
  logic [63:0] out_flit;
  logic out_ready;
  logic [3:0] vc_empty;
  logic err_clr;
  logic [1:0] err_status;
  int checks = 0;
  int errors = 0;
  int ev [6] = '{3, 0, 1, 2, 0, 1};
  int qv [5] = '{0, 1, 2, 0, 1};
  logic [63:0] ef [6];

  noc_vc_input_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_vc     (in_vc),
    .in_flit   (in_flit),
    .credit_ret(credit_ret),
    .out_valid (out_valid),
    .out_vc    (out_vc),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .vc_empty  (vc_empty),
    .err_clr   (err_clr),
    .err_status(err_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // top bit makes the whole flit even parity, valid with or without checking
  function automatic logic [63:0] mk(input logic [62:0] p);
    return {^p, p};
  endfunction

  task automatic drive(input logic v, input int vc, input logic [63:0] f);
    in_valid = v;
    in_vc = 2'(vc);
    in_flit = f;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_vc = '0;
    in_flit = '0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_credit", 64'(credit_ret), 0);
    chk("rst_empty", 64'(vc_empty), 4'hf);
    chk("rst_err", 64'(err_status), 0);
    rst_n = 1'b1;
    // single flit on VC2
    drive(1, 2, mk(63'h100));
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 1);
    chk("t1_vc", 64'(out_vc), 2);
    chk("t1_flit", out_flit, mk(63'h100));
    chk("t1_empty", 64'(vc_empty), 4'b1011);
    @(negedge clk);
    chk("t1_credit", 64'(credit_ret), 4'b0100);
    chk("t1_idle", 64'(out_valid), 0);
    @(negedge clk);
    chk("t1_credit_once", 64'(credit_ret), 0);
    // overflow VC0
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, mk(63'h200 + 63'(i)));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t2_ovf", 64'(err_status), 2'b01);
    chk("t2_vc", 64'(out_vc), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_clr", 64'(err_status), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", out_flit, mk(63'h200 + 63'(i)));
      @(negedge clk);
      chk("t2_credit", 64'(credit_ret), 4'b0001);
    end
    chk("t2_drained", 64'(out_valid), 0);
    out_ready = 1'b0;
    // one flit per VC, round-robin order
    for (int i = 0; i < 4; i++) begin
      drive(1, i, mk(63'h300 + 63'(i)));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_vc", 64'(out_vc), 64'(i));
      chk("t3_flit", out_flit, mk(63'h300 + 63'(i)));
      @(negedge clk);
    end
    chk("t3_drained", 64'(out_valid), 0);
    drive(1, 1, mk(63'h310));
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_vc1", 64'(out_vc), 1);
    chk("t3_vc1_flit", out_flit, mk(63'h310));
    @(negedge clk);
    out_ready = 1'b0;
    // stall with arrivals on other VCs
    drive(1, 3, mk(63'h400));
    @(negedge clk);
    chk("t4_vc", 64'(out_vc), 3);
    for (int i = 0; i < 5; i++) begin
      drive(1, qv[i], mk(63'h500 + 63'(i)));
      @(negedge clk);
      chk("t4_hold_vc", 64'(out_vc), 3);
      chk("t4_hold_flit", out_flit, mk(63'h400));
    end
    in_valid = 1'b0;
    ef[0] = mk(63'h400);
    for (int i = 0; i < 5; i++) ef[i+1] = mk(63'h500 + 63'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t4_drain_vc", 64'(out_vc), 64'(ev[i]));
      chk("t4_drain_flit", out_flit, ef[i]);
      @(negedge clk);
    end
    chk("t4_drained", 64'(out_valid), 0);
    out_ready = 1'b0;
    // full VC1 with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, mk(63'h600 + 63'(i)));
      @(negedge clk);
    end
    chk("t5_vc", 64'(out_vc), 1);
    drive(1, 1, mk(63'h604));
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_no_err", 64'(err_status), 0);
    chk("t5_credit", 64'(credit_ret), 4'b0010);
    chk("t5_head", out_flit, mk(63'h601));
    drive(1, 1, mk(63'h605));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_clr_prio", 64'(err_status), 0);
    drive(1, 1, mk(63'h606));
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_still_full", 64'(err_status), 2'b01);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("t5_order", out_flit, mk(63'h600 + 63'(i)));
      @(negedge clk);
    end
    chk("t5_empty", 64'(vc_empty), 4'hf);
    out_ready = 1'b0;
`ifdef NOC_VCBUF_PARITY_EN
    drive(1, 3, mk(63'h700) ^ {1'b1, 63'b0});
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_par_err", 64'(err_status), 2'b10);
    chk("t6_credit", 64'(credit_ret), 4'b1000);
    chk("t6_not_out", 64'(out_valid), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_clr", 64'(err_status), 0);
    chk("t6_credit_once", 64'(credit_ret), 0);
`endif
    // reset with flits buffered
    drive(1, 0, mk(63'h800));
    @(negedge clk);
    drive(1, 2, mk(63'h801));
    @(negedge clk);
    in_valid = 1'b0;
    chk("t7_loaded", 64'(vc_empty), 4'b1010);
    rst_n = 1'b0;
    #1;
    chk("t7_empty", 64'(vc_empty), 4'hf);
    chk("t7_valid", 64'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_no_credit", 64'(credit_ret), 0);
    chk("t7_idle", 64'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
